// File: rtl/pwm_cfg_pkg.sv
// Shared types and register-map constants for the PWM configuration sequencer.
package pwm_cfg_pkg;

  localparam int CFG_DW     = 32;
  localparam int NUM_WRITES = 5;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DIV    = 8'h04;
  localparam logic [7:0] OFF_PERIOD = 8'h08;
  localparam logic [7:0] OFF_DUTY   = 8'h0C;

  localparam logic [7:0] BASE_CH1 = 8'h00;
  localparam logic [7:0] BASE_CH2 = 8'h10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              ch;
    logic [CFG_DW-1:0] div;
    logic [CFG_DW-1:0] period;
    logic [CFG_DW-1:0] duty;
    logic [7:0]        ctrl;
  } cfg_t;

  // Write slot 0 and 4 both target CTRL (disable first, final value last).
  function automatic logic [7:0] wr_addr(input logic ch, input logic [2:0] idx);
    logic [7:0] off;
    case (idx)
      3'd1:    off = OFF_DIV;
      3'd2:    off = OFF_PERIOD;
      3'd3:    off = OFF_DUTY;
      default: off = OFF_CTRL;
    endcase
    return (ch ? BASE_CH2 : BASE_CH1) + off;
  endfunction

endpackage

// File: rtl/pwm_rr_arb2.sv
// Two-requester round-robin arbiter; pointer holds the last winner.
module pwm_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       winner,
  output logic       valid
);

  logic ptr;

  always_comb begin
    valid  = |req;
    winner = (&req) ? ~ptr : req[1];
  end

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b1;
    else if (take && valid)
      ptr <= winner;
  end

endmodule

// File: rtl/pwm_cfg_seq.sv
// APB master that programs one PWM channel with a fixed five-write burst for the granted requester.
// state  | meaning
// IDLE   | waiting for a request, arbitrating and latching config
// SETUP  | APB setup phase of write idx
// ACCESS | APB access phase, waiting for PREADY or timeout
// DONE   | one-cycle done/err pulse to the owner
module pwm_cfg_seq
  import pwm_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DW,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                    PCLK_i,
  input  logic                    PRST_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              req_ch_i,
  input  logic [2*DATA_WIDTH-1:0] req_div_i,
  input  logic [2*DATA_WIDTH-1:0] req_period_i,
  input  logic [2*DATA_WIDTH-1:0] req_duty_i,
  input  logic [15:0]             req_ctrl_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              done_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    PSEL_o,
  output logic                    PENABLE_o,
  output logic                    PWRITE_o,
  output logic [ADDR_WIDTH-1:0]   PADDR_o,
  output logic [DATA_WIDTH-1:0]   PWDATA_o,
  input  logic                    PREADY_i,
  input  logic                    PSLVERR_i
);

  state_t          state, state_nxt;
  cfg_t            cfg;
  logic            owner;
  logic [2:0]      idx;
  logic [7:0]      tcnt;
  logic            err_q;
  logic            win, win_valid;
  logic            last, tmo;
  logic [1:0]      owner_oh;
  logic [DATA_WIDTH-1:0] wr_data;

  pwm_rr_arb2 u_arb (
    .clk    (PCLK_i),
    .rst_n  (PRST_ni),
    .req    (req_i),
    .take   (state == IDLE),
    .winner (win),
    .valid  (win_valid)
  );

  assign last     = (idx == 3'(NUM_WRITES - 1));
  assign tmo      = (tcnt == 8'(TIMEOUT - 1));
  assign owner_oh = owner ? 2'b10 : 2'b01;

  always_ff @(posedge PCLK_i or negedge PRST_ni) begin
    if (!PRST_ni)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY_i)
          state_nxt = (PSLVERR_i || last) ? DONE : SETUP;
        else if (tmo)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // err_q is rewritten on every ACCESS cycle; only the value from the final one reaches DONE.
  always_ff @(posedge PCLK_i or negedge PRST_ni) begin
    if (!PRST_ni) begin
      cfg   <= '0;
      owner <= 1'b0;
      idx   <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_valid) begin
          cfg.ch     <= req_ch_i[win];
          cfg.div    <= req_div_i[(win ? DATA_WIDTH : 0) +: DATA_WIDTH];
          cfg.period <= req_period_i[(win ? DATA_WIDTH : 0) +: DATA_WIDTH];
          cfg.duty   <= req_duty_i[(win ? DATA_WIDTH : 0) +: DATA_WIDTH];
          cfg.ctrl   <= req_ctrl_i[(win ? 8 : 0) +: 8];
          owner      <= win;
          idx        <= '0;
        end
        SETUP: tcnt <= '0;
        ACCESS: begin
          if (PREADY_i) begin
            err_q <= PSLVERR_i;
            if (!PSLVERR_i && !last)
              idx <= idx + 3'd1;
          end else begin
            err_q <= 1'b1;
            tcnt  <= tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (idx)
      3'd1:    wr_data = cfg.div;
      3'd2:    wr_data = cfg.period;
      3'd3:    wr_data = cfg.duty;
      3'd4:    wr_data = DATA_WIDTH'(cfg.ctrl);
      default: wr_data = '0;
    endcase
  end

  always_comb begin
    PSEL_o    = 1'b0;
    PENABLE_o = 1'b0;
    PWRITE_o  = 1'b0;
    PADDR_o   = '0;
    PWDATA_o  = '0;
    gnt_o     = '0;
    done_o    = '0;
    err_o     = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      SETUP, ACCESS: begin
        PSEL_o    = 1'b1;
        PENABLE_o = (state == ACCESS);
        PWRITE_o  = 1'b1;
        PADDR_o   = ADDR_WIDTH'(wr_addr(cfg.ch, idx));
        PWDATA_o  = wr_data;
        gnt_o     = owner_oh;
      end
      DONE: begin
        done_o = owner_oh;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// Scoreboard bench for pwm_cfg_seq: expected grants, APB writes and done pulses are queued
// when a request is issued and popped as the DUT produces them.
module tb_pwm_cfg_seq;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0] oh;
    logic       err;
    int         lat;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_ch;
  logic [63:0] req_div, req_period, req_duty;
  logic [15:0] req_ctrl;
  logic [1:0]  gnt, done;
  logic        err, busy, psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;

  wr_t   wr_q[$];
  done_t done_q[$];
  logic [1:0] gnt_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_seen = 0;
  int burst_wr = 0;
  int wait_n = 0;
  int stall_wr = -1;
  int stall_len = 0;
  int err_wr = -1;
  logic [1:0]  prev_gnt = 2'b00;
  logic        prev_setup = 1'b0;
  logic [7:0]  hold_addr;
  logic [31:0] hold_data;
  wr_t   w_e;
  done_t d_e;

  pwm_cfg_seq dut (
    .PCLK_i       (clk),
    .PRST_ni      (rst_n),
    .req_i        (req),
    .req_ch_i     (req_ch),
    .req_div_i    (req_div),
    .req_period_i (req_period),
    .req_duty_i   (req_duty),
    .req_ctrl_i   (req_ctrl),
    .gnt_o        (gnt),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .PSEL_o       (psel),
    .PENABLE_o    (penable),
    .PWRITE_o     (pwrite),
    .PADDR_o      (paddr),
    .PWDATA_o     (pwdata),
    .PREADY_i     (pready),
    .PSLVERR_i    (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic set_fields(input int r, input logic ch, input logic [31:0] dv, input logic [31:0] pr,
                            input logic [31:0] dt, input logic [7:0] ct);
    req_ch[r]             = ch;
    req_div[r*32 +: 32]    = dv;
    req_period[r*32 +: 32] = pr;
    req_duty[r*32 +: 32]   = dt;
    req_ctrl[r*8 +: 8]     = ct;
  endtask

  task automatic push_burst(input int r, input logic ch, input logic [31:0] dv, input logic [31:0] pr,
                            input logic [31:0] dt, input logic [7:0] ct, input int n_wr,
                            input logic e, input bit has_done, input int lat);
    logic [7:0]  base;
    logic [7:0]  a[5];
    logic [31:0] d[5];
    wr_t   w;
    done_t dn;
    base = ch ? 8'h10 : 8'h00;
    a = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h00};
    d = '{32'h0, dv, pr, dt, {24'h0, ct}};
    gnt_q.push_back(r == 0 ? 2'b01 : 2'b10);
    for (int i = 0; i < n_wr; i++) begin
      w.addr = base + a[i];
      w.data = d[i];
      wr_q.push_back(w);
    end
    if (has_done) begin
      dn.oh  = (r == 0) ? 2'b01 : 2'b10;
      dn.err = e;
      dn.lat = lat;
      done_q.push_back(dn);
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (done_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_seen < target) chk("wait_done_bound", 32'(done_seen), 32'(target));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_psel"},    32'(psel),    32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_pwrite"},  32'(pwrite),  32'd0);
    chk({tag, "_paddr"},   32'(paddr),   32'd0);
    chk({tag, "_pwdata"},  pwdata,       32'd0);
    chk({tag, "_gnt"},     32'(gnt),     32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
  endtask

  // APB slave responder and scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      burst_wr   = 0;
      wait_n     = 0;
      prev_gnt   = 2'b00;
      prev_setup = 1'b0;
      pready     = 1'b1;
      pslverr    = 1'b0;
    end else begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        if (gnt_q.size() > 0) chk("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
        else chk("gnt_unexpected", 32'(gnt), 32'd0);
      end
      prev_gnt = gnt;
      pready   = 1'b1;
      pslverr  = 1'b0;
      if (psel && penable) begin
        if (wait_n == 0) begin
          chk("setup_before_access", 32'(prev_setup), 32'd1);
          chk("pwrite", 32'(pwrite), 32'd1);
        end
        if (burst_wr == stall_wr && wait_n < stall_len) begin
          pready = 1'b0;
          if (wait_n == 0) begin
            hold_addr = paddr;
            hold_data = pwdata;
          end else begin
            chk("hold_paddr", 32'(paddr), 32'(hold_addr));
            chk("hold_pwdata", pwdata, hold_data);
          end
          wait_n++;
        end else begin
          pslverr = (burst_wr == err_wr);
          if (wr_q.size() > 0) begin
            w_e = wr_q.pop_front();
            chk("paddr", 32'(paddr), 32'(w_e.addr));
            chk("pwdata", pwdata, w_e.data);
          end else begin
            chk("write_unexpected", 32'(paddr), 32'hFFFF_FFFF);
          end
          burst_wr++;
          wait_n = 0;
        end
      end
      prev_setup = psel && !penable;
      if (done != 2'b00) begin
        if (done_q.size() > 0) begin
          d_e = done_q.pop_front();
          chk("done", 32'(done), 32'(d_e.oh));
          chk("err", 32'(err), 32'(d_e.err));
          if (d_e.lat >= 0) chk("done_latency", 32'(cyc - req_cyc), 32'(d_e.lat));
        end else begin
          chk("done_unexpected", 32'(done), 32'd0);
        end
        chk("psel_at_done", 32'(psel), 32'd0);
        chk("gnt_at_done", 32'(gnt), 32'd0);
        done_seen++;
        burst_wr = 0;
        wait_n   = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int tgt;
    int n;
    rst_n = 1'b0;
    req = '0; req_ch = '0; req_div = '0; req_period = '0; req_duty = '0; req_ctrl = '0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Single requester, nominal latency 11.
    set_fields(0, 1'b0, 32'd4, 32'd100, 32'd25, 8'h07);
    push_burst(0, 1'b0, 32'd4, 32'd100, 32'd25, 8'h07, 5, 1'b0, 1'b1, 11);
    @(posedge clk); #1;
    req[0] = 1'b1; req_cyc = cyc;
    wait_dones(1, 60);
    req[0] = 1'b0;

    // Contention out of reset: alternation 01, 10, 01.
    reset_dut();
    set_fields(0, 1'b0, 32'h11, 32'h22, 32'h33, 8'h44);
    set_fields(1, 1'b1, 32'hA1, 32'hA2, 32'hA3, 8'hA4);
    push_burst(0, 1'b0, 32'h11, 32'h22, 32'h33, 8'h44, 5, 1'b0, 1'b1, -1);
    push_burst(1, 1'b1, 32'hA1, 32'hA2, 32'hA3, 8'hA4, 5, 1'b0, 1'b1, -1);
    push_burst(0, 1'b0, 32'h11, 32'h22, 32'h33, 8'h44, 5, 1'b0, 1'b1, -1);
    tgt = done_seen + 3;
    @(posedge clk); #1;
    req = 2'b11;
    wait_dones(tgt, 120);
    req = 2'b00;

    // Three wait states on the DIV write; input fields scrambled after grant.
    stall_wr = 1; stall_len = 3;
    set_fields(0, 1'b1, 32'd9, 32'd200, 32'd50, 8'h03);
    push_burst(0, 1'b1, 32'd9, 32'd200, 32'd50, 8'h03, 5, 1'b0, 1'b1, 14);
    tgt = done_seen + 1;
    @(posedge clk); #1;
    req[0] = 1'b1; req_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 set_fields(0, 1'b0, 32'hDEAD, 32'hBEEF, 32'hCAFE, 8'hFF);
    wait_dones(tgt, 60);
    req[0] = 1'b0;
    stall_wr = -1; stall_len = 0;

    // Slave error on PERIOD; request dropped mid-burst.
    err_wr = 2;
    set_fields(1, 1'b0, 32'd1, 32'd2, 32'd3, 8'h81);
    push_burst(1, 1'b0, 32'd1, 32'd2, 32'd3, 8'h81, 3, 1'b1, 1'b1, 7);
    tgt = done_seen + 1;
    @(posedge clk); #1;
    req[1] = 1'b1; req_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 req[1] = 1'b0;
    wait_dones(tgt, 60);
    err_wr = -1;

    // PREADY never arrives: forced abort after 255 ACCESS cycles.
    stall_wr = 0; stall_len = 1000;
    set_fields(0, 1'b0, 32'd5, 32'd6, 32'd7, 8'h01);
    push_burst(0, 1'b0, 32'd5, 32'd6, 32'd7, 8'h01, 0, 1'b1, 1'b1, 257);
    tgt = done_seen + 1;
    @(posedge clk); #1;
    req[0] = 1'b1; req_cyc = cyc;
    wait_dones(tgt, 400);
    req[0] = 1'b0;
    stall_wr = -1; stall_len = 0;

    // Reset during the DUTY access, then restart with the request still held.
    set_fields(0, 1'b1, 32'd11, 32'd22, 32'd33, 8'h05);
    push_burst(0, 1'b1, 32'd11, 32'd22, 32'd33, 8'h05, 4, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    req[0] = 1'b1;
    n = 0;
    while (!(psel && penable && paddr == 8'h1C) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("duty_access_bound", 32'(paddr), 32'h1C);
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    push_burst(0, 1'b1, 32'd11, 32'd22, 32'd33, 8'h05, 5, 1'b0, 1'b1, -1);
    tgt = done_seen + 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_dones(tgt, 60);
    req[0] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("done_q_left", 32'(done_q.size()), 32'd0);
    chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
